// File: rtl/quad_decoder.sv
// Quadrature rotary-encoder decoder: pin synchronisers, per-phase debounce,
// detent scaling and a bounded wrap/saturate position counter.
module quad_decoder #(
    parameter int WIDTH            = 8,
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_BITS    = 11,
    parameter int STEPS_PER_DETENT = 4,
    parameter int SATURATE         = 0,
    parameter int MIN_VAL          = 0,
    parameter int MAX_VAL          = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             step_up,
    output logic             step_down,
    output logic             error,
    output logic [7:0]       error_count
);
    localparam logic [WIDTH-1:0]  MIN_W    = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0]  MAX_W    = WIDTH'(MAX_VAL);
    localparam logic signed [3:0] STEP_POS = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0] STEP_NEG = -STEP_POS;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        if (int'(v) < MIN_VAL) return MIN_W;
        if (int'(v) > MAX_VAL) return MAX_W;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] step_inc(input logic [WIDTH-1:0] c);
        if (c == MAX_W) return (SATURATE != 0) ? c : MIN_W;
        return c + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] step_dec(input logic [WIDTH-1:0] c);
        if (c == MIN_W) return (SATURATE != 0) ? c : MAX_W;
        return c - 1'b1;
    endfunction

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             ab_sync;
    logic [1:0]             ab_db;

    // Synchroniser chains idle high, matching the pulled-up pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], b};
        end
    end

    assign ab_sync = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    generate
        if (DEBOUNCE_BITS == 0) begin : g_bypass
            assign ab_db = ab_sync;
        end else begin : g_debounce
            for (genvar i = 0; i < 2; i++) begin : g_phase
                logic [DEBOUNCE_BITS-1:0] stable;
                logic [DEBOUNCE_BITS-1:0] stable_next;
                logic                     last;
                logic                     db;

                always_comb begin
                    stable_next = stable;
                    if (ab_sync[i] != last)
                        stable_next = '0;
                    else if (stable != {DEBOUNCE_BITS{1'b1}})
                        stable_next = stable + 1'b1;
                end

                // Accept on the edge where the counter reaches terminal, so the
                // added latency is exactly 2^DEBOUNCE_BITS cycles
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stable <= '0;
                        last   <= 1'b1;
                        db     <= 1'b1;
                    end else begin
                        stable <= stable_next;
                        last   <= ab_sync[i];
                        if (stable_next == {DEBOUNCE_BITS{1'b1}})
                            db <= ab_sync[i];
                    end
                end

                assign ab_db[i] = db;
            end
        end
    endgenerate

    logic [1:0]        prev;
    logic signed [2:0] acc;
    logic signed [2:0] acc_next;
    logic signed [3:0] delta;
    logic signed [3:0] acc_sum;
    logic              mv_up;
    logic              mv_dn;
    logic              illegal;
    logic [WIDTH-1:0]  count_next;
    logic              up_next;
    logic              dn_next;
    logic [7:0]        errc_next;

    always_comb begin
        mv_up   = 1'b0;
        mv_dn   = 1'b0;
        illegal = 1'b0;
        case ({prev, ab_db})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: mv_up   = 1'b1;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: mv_dn   = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        delta      = mv_up ? 4'sd1 : (mv_dn ? -4'sd1 : 4'sd0);
        acc_sum    = $signed({acc[2], acc}) + delta;
        count_next = count;
        acc_next   = acc;
        up_next    = 1'b0;
        dn_next    = 1'b0;
        errc_next  = (illegal && error_count != 8'hFF) ? error_count + 8'd1 : error_count;
        // load/clear swallow any step in the same cycle; error still reported
        if (load) begin
            count_next = clamp_load(load_value);
            acc_next   = '0;
        end else if (clear) begin
            count_next = MIN_W;
            acc_next   = '0;
        end else if (illegal) begin
            acc_next = '0;
        end else if (mv_up && acc_sum == STEP_POS) begin
            acc_next   = '0;
            up_next    = 1'b1;
            count_next = step_inc(count);
        end else if (mv_dn && acc_sum == STEP_NEG) begin
            acc_next   = '0;
            dn_next    = 1'b1;
            count_next = step_dec(count);
        end else if (mv_up || mv_dn) begin
            acc_next = acc_sum[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev        <= 2'b11;
            acc         <= '0;
            count       <= MIN_W;
            step_up     <= 1'b0;
            step_down   <= 1'b0;
            error       <= 1'b0;
            error_count <= '0;
        end else begin
            prev        <= ab_db;
            acc         <= acc_next;
            count       <= count_next;
            step_up     <= up_next;
            step_down   <= dn_next;
            error       <= illegal;
            error_count <= errc_next;
        end
    end
endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: three instances (plain, saturating, debounced)
// driven at pin level and checked against a position/phase reference model.
module tb_quad_decoder;
    localparam int W = 9;
    localparam int P_MIN   [3] = '{0, 3, 0};
    localparam int P_MAX   [3] = '{255, 5, 255};
    localparam int P_STEPS [3] = '{4, 1, 1};
    localparam int P_SAT   [3] = '{0, 1, 0};
    localparam int P_LAT   [3] = '{3, 3, 19};

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   a     = '1;
    logic [2:0]   b     = '1;
    logic [2:0]   clr   = '0;
    logic [2:0]   ld    = '0;
    logic [2:0]   su;
    logic [2:0]   sd;
    logic [2:0]   er;
    logic [W-1:0] lv  [3];
    logic [W-1:0] cnt [3];
    logic [7:0]   ec  [3];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    quad_decoder #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_BITS(0), .STEPS_PER_DETENT(4),
                   .SATURATE(0), .MIN_VAL(0), .MAX_VAL(255)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a[0]), .b(b[0]), .clear(clr[0]), .load(ld[0]),
        .load_value(lv[0]), .count(cnt[0]), .step_up(su[0]), .step_down(sd[0]),
        .error(er[0]), .error_count(ec[0]));

    quad_decoder #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_BITS(0), .STEPS_PER_DETENT(1),
                   .SATURATE(1), .MIN_VAL(3), .MAX_VAL(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a[1]), .b(b[1]), .clear(clr[1]), .load(ld[1]),
        .load_value(lv[1]), .count(cnt[1]), .step_up(su[1]), .step_down(sd[1]),
        .error(er[1]), .error_count(ec[1]));

    quad_decoder #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_BITS(4), .STEPS_PER_DETENT(1),
                   .SATURATE(0), .MIN_VAL(0), .MAX_VAL(255)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a[2]), .b(b[2]), .clear(clr[2]), .load(ld[2]),
        .load_value(lv[2]), .count(cnt[2]), .step_up(su[2]), .step_down(sd[2]),
        .error(er[2]), .error_count(ec[2]));

    typedef struct {
        int id;
        int kind;   // 1 up, 2 down, 3 error
        int cnt;
        int ec;
        int at;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  m_cnt [3];
    int  m_acc [3];
    int  m_ec  [3];
    int  m_ph  [3];   // phase the decoder has seen: 0=00 1=10 2=11 3=01
    int  pp    [3];   // phase currently on the pins

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ph2ab(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int next_count(input int id, input int dir, input int c);
        if (dir > 0) return (c == P_MAX[id]) ? ((P_SAT[id] != 0) ? c : P_MIN[id]) : c + 1;
        return (c == P_MIN[id]) ? ((P_SAT[id] != 0) ? c : P_MAX[id]) : c - 1;
    endfunction

    function automatic int clampv(input int id, input int v);
        if (v < P_MIN[id]) return P_MIN[id];
        if (v > P_MAX[id]) return P_MAX[id];
        return v;
    endfunction

    function automatic void push_ev(input int id, input int kind);
        ev_t e;
        e.id   = id;
        e.kind = kind;
        e.cnt  = m_cnt[id];
        e.ec   = m_ec[id];
        e.at   = cyc + P_LAT[id];
        q.push_back(e);
    endfunction

    // Position step seen by the decoder: +1 up, -1 down, 2 illegal jump
    function automatic void model_see(input int id, input int p);
        int d;
        d = (p - m_ph[id] + 4) % 4;
        m_ph[id] = p;
        if (d == 2) begin
            m_acc[id] = 0;
            if (m_ec[id] < 255) m_ec[id]++;
            push_ev(id, 3);
        end else if (d == 1) begin
            m_acc[id]++;
            if (m_acc[id] == P_STEPS[id]) begin
                m_acc[id] = 0;
                m_cnt[id] = next_count(id, 1, m_cnt[id]);
                push_ev(id, 1);
            end
        end else if (d == 3) begin
            m_acc[id]--;
            if (m_acc[id] == -P_STEPS[id]) begin
                m_acc[id] = 0;
                m_cnt[id] = next_count(id, -1, m_cnt[id]);
                push_ev(id, 2);
            end
        end
    endfunction

    task automatic set_pins(input int id, input int p, input int hold);
        logic [1:0] ab;
        @(negedge clk);
        ab     = ph2ab(p);
        a[id]  = ab[1];
        b[id]  = ab[0];
        pp[id] = p;
        model_see(id, p);
        repeat (hold) @(negedge clk);
    endtask

    task automatic move(input int id, input int dir, input int hold);
        set_pins(id, (pp[id] + dir + 4) % 4, hold);
    endtask

    task automatic do_load(input int id, input int v);
        @(negedge clk);
        ld[id] = 1'b1;
        lv[id] = W'(v);
        @(negedge clk);
        ld[id]    = 1'b0;
        m_cnt[id] = clampv(id, v);
        m_acc[id] = 0;
        chk($sformatf("load_dut%0d_v%0d", id, v), int'(cnt[id]), m_cnt[id]);
    endtask

    task automatic do_clear(input int id);
        @(negedge clk);
        clr[id] = 1'b1;
        @(negedge clk);
        clr[id]   = 1'b0;
        m_cnt[id] = P_MIN[id];
        m_acc[id] = 0;
        chk($sformatf("clear_dut%0d", id), int'(cnt[id]), m_cnt[id]);
    endtask

    task automatic reset_all(input int low_cycles);
        @(negedge clk);
        chk("queue_empty_before_reset", q.size(), 0);
        q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_count_dut%0d", i), int'(cnt[i]), P_MIN[i]);
            chk($sformatf("rst_errcnt_dut%0d", i), int'(ec[i]), 0);
            chk($sformatf("rst_pulses_dut%0d", i), int'({su[i], sd[i], er[i]}), 0);
        end
        repeat (low_cycles) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = P_MIN[i];
            m_acc[i] = 0;
            m_ec[i]  = 0;
            m_ph[i]  = 2;
            model_see(i, pp[i]);
        end
    endtask

    task automatic rand_walk(input int id, input int n, input int hold);
        for (int k = 0; k < n; k++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 2)       do_load(id, $urandom_range(0, 511));
            else if (r < 4)  do_clear(id);
            else if (r < 6)  move(id, 2, hold);
            else if (r < 13) move(id, 1, hold);
            else             move(id, -1, hold);
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        int  kind;
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (su[i] || sd[i] || er[i]) begin
                    chk($sformatf("one_hot_dut%0d", i), int'(su[i]) + int'(sd[i]) + int'(er[i]), 1);
                    kind = su[i] ? 1 : (sd[i] ? 2 : 3);
                    if (q.size() == 0) begin
                        chk($sformatf("spurious_pulse_dut%0d", i), kind, 0);
                    end else begin
                        e = q.pop_front();
                        chk("ev_dut", i, e.id);
                        chk($sformatf("ev_kind_dut%0d", i), kind, e.kind);
                        chk($sformatf("ev_count_dut%0d", i), int'(cnt[i]), e.cnt);
                        chk($sformatf("ev_errcnt_dut%0d", i), int'(ec[i]), e.ec);
                        chk($sformatf("ev_cycle_dut%0d", i), cyc, e.at);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            lv[i] = '0;
            pp[i] = 2;
        end
        reset_all(3);

        // two full up cycles, then wrap down from zero, then clamped load
        repeat (8) move(0, 1, 4);
        chk("dut0_two_detents", int'(cnt[0]), 2);
        do_clear(0);
        repeat (4) move(0, -1, 4);
        chk("dut0_wrap_down", int'(cnt[0]), 255);
        do_load(0, 300);
        chk("dut0_load_clamp", int'(cnt[0]), 255);

        // illegal jumps: count held, error_count saturates
        move(0, 2, 4);
        chk("dut0_errcnt_first", int'(ec[0]), 1);
        chk("dut0_err_holds_count", int'(cnt[0]), 255);
        repeat (299) move(0, 2, 2);
        repeat (4) @(negedge clk);
        chk("dut0_errcnt_sat", int'(ec[0]), 255);

        // saturating instance climbs to MAX and holds, still pulsing
        repeat (5) move(1, 1, 4);
        chk("dut1_sat_hold", int'(cnt[1]), 5);
        do_clear(1);
        chk("dut1_clear_min", int'(cnt[1]), 3);

        rand_walk(0, 80, 4);
        rand_walk(1, 60, 4);

        // debounce: short glitch rejected, held level accepted
        @(negedge clk);
        a[2] = 1'b0;
        repeat (10) @(negedge clk);
        a[2] = 1'b1;
        repeat (30) @(negedge clk);
        chk("dut2_glitch_count", int'(cnt[2]), 0);
        chk("dut2_glitch_no_event", q.size(), 0);
        move(2, 1, 25);
        chk("dut2_held_accepted", int'(cnt[2]), 1);
        for (int k = 0; k < 8; k++) move(2, ($urandom_range(0, 1) != 0) ? 1 : -1, 22);

        // reset in the middle of a detent discards the partial steps
        repeat (3) move(0, 1, 4);
        reset_all(2);
        move(0, 1, 6);
        chk("dut0_after_midreset", int'(cnt[0]), 0);

        repeat (40) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
